// File: rtl/sram_mem_controller.sv
// MEM-stage load/store responder: serves each 32-bit word as two 16-bit
// accesses to an external single-port SRAM, holding ready low until done.
module sram_mem_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            wr_data,
    output logic [31:0]            rd_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_we_n
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned IDX_W = SRAM_ADDR_W - 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic                   is_wr;
    logic [IDX_W-1:0]       idx;
    logic [31:0]            data;

    logic                   req_c, last_c, latch_c, cap_lo_c, cap_hi_c;
    logic [IDX_W-1:0]       idx_c;
    logic [SRAM_ADDR_W-1:0] addr_nx;
    logic [15:0]            dq_out_nx;
    logic                   we_n_nx;

    // Word index relative to the data-memory base, wrapping modulo 2^32
    assign idx_c  = IDX_W'((address - 32'(BASE_ADDR)) >> 2);
    assign req_c  = rd_en || wr_en;
    assign last_c = (cnt == CNT_W'(WAIT_CYCLES - 1));
    assign ready  = ((state == IDLE) && !req_c) || (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state plus next values of the registered SRAM-side outputs
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        latch_c   = 1'b0;
        cap_lo_c  = 1'b0;
        cap_hi_c  = 1'b0;
        addr_nx   = sram_addr;
        dq_out_nx = sram_dq_out;
        we_n_nx   = 1'b1;
        case (state)
            IDLE: begin
                if (req_c) begin
                    latch_c  = 1'b1;
                    state_nx = LOW;
                    cnt_nx   = '0;
                    addr_nx  = {idx_c, 1'b0};
                    we_n_nx  = !wr_en;
                    if (wr_en) dq_out_nx = wr_data[15:0];
                end
            end
            LOW: begin
                we_n_nx = !is_wr;
                if (last_c) begin
                    cap_lo_c = !is_wr;
                    state_nx = HIGH;
                    cnt_nx   = '0;
                    addr_nx  = {idx, 1'b1};
                    if (is_wr) dq_out_nx = data[31:16];
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (last_c) begin
                    cap_hi_c = !is_wr;
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    we_n_nx = !is_wr;
                    cnt_nx  = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_wr       <= 1'b0;
            idx         <= '0;
            data        <= '0;
            rd_data     <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
        end else begin
            if (latch_c) begin
                is_wr <= wr_en;
                idx   <= idx_c;
                data  <= wr_data;
            end
            if (cap_lo_c) rd_data[15:0]  <= sram_dq_in;
            if (cap_hi_c) rd_data[31:16] <= sram_dq_in;
            sram_addr   <= addr_nx;
            sram_dq_out <= dq_out_nx;
            sram_we_n   <= we_n_nx;
            sram_dq_oe  <= !we_n_nx;
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a small behavioural SRAM.
module tb_sram_mem_controller;

    localparam int unsigned W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, wr_data, rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic [15:0] mem [16];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W), .SRAM_ADDR_W(18)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .wr_data(wr_data), .rd_data(rd_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    // SRAM model: preload during reset, write on strobe, asynchronous read
    always @(posedge clk) begin
        if (rst) begin
            mem[8] <= 16'h5A5A;
            mem[9] <= 16'hC3C3;
        end else if (!sram_we_n) begin
            mem[sram_addr[3:0]] <= sram_dq_out;
        end
    end
    assign sram_dq_in = mem[sram_addr[3:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n, input logic [31:0] exp_rd);
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_we_n", 32'(sram_we_n), 32'd1);
            chk("idle_oe", 32'(sram_dq_oe), 32'd0);
            chk("idle_rd_data", rd_data, exp_rd);
            @(posedge clk); #1;
        end
    endtask

    // Request stays asserted on return so a following call runs back-to-back
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] dat, input logic [17:0] exp_sa,
                          input logic [31:0] exp_rd);
        wr_en   = wr;
        rd_en   = rd;
        address = addr;
        wr_data = dat;
        for (int c = 0; c <= 2 * W + 1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("c0_ready", 32'(ready), 32'd0);
                chk("c0_we_n", 32'(sram_we_n), 32'd1);
            end else if (c <= 2 * W) begin
                chk("acc_ready", 32'(ready), 32'd0);
                chk("acc_addr", 32'(sram_addr), 32'(exp_sa + ((c > W) ? 18'd1 : 18'd0)));
                chk("acc_we_n", 32'(sram_we_n), 32'(!wr));
                chk("acc_oe", 32'(sram_dq_oe), 32'(wr));
                if (wr) chk("acc_dq_out", 32'(sram_dq_out), (c > W) ? 32'(dat[31:16]) : 32'(dat[15:0]));
            end else begin
                chk("done_ready", 32'(ready), 32'd1);
                chk("done_we_n", 32'(sram_we_n), 32'd1);
                chk("done_oe", 32'(sram_dq_oe), 32'd0);
                chk("done_rd_data", rd_data, exp_rd);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        idle(3, 32'd0);
        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 32'd0);
        idle(1, 32'd0);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'hDEADBEEF);
        idle(3, 32'hDEADBEEF);
        access(1'b1, 1'b1, 32'd1030, 32'h12345678, 18'd2, 32'hDEADBEEF);
        idle(1, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1040, 32'h0, 18'd8, 32'hC3C35A5A);
        idle(1, 32'hC3C35A5A);
        access(1'b1, 1'b0, 32'd1028, 32'hAAAA5555, 18'd2, 32'hC3C35A5A);
        access(1'b1, 1'b0, 32'd1032, 32'h0F0FF0F0, 18'd4, 32'hC3C35A5A);
        idle(1, 32'hC3C35A5A);
        access(1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, 18'h3FFFE, 32'hC3C35A5A);
        idle(1, 32'hC3C35A5A);
        access(1'b0, 1'b1, 32'd1020, 32'h0, 18'h3FFFE, 32'hCAFEF00D);
        idle(1, 32'hCAFEF00D);

        // Reset in the first HIGH cycle of a write
        wr_en = 1'b1; address = 32'd1024; wr_data = 32'h11112222;
        repeat (3) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst3_we_n_before", 32'(sram_we_n), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst3_we_n", 32'(sram_we_n), 32'd1);
        chk("rst3_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst3_rd_data", rd_data, 32'd0);
        chk("rst3_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
